// File: rtl/serial_sub_nbit.sv
// ============================================================================
// Module   : serial_sub_nbit
// Purpose  : Bit-serial N-bit subtractor (A - B, LSB first, one bit per clock)
//            with a start/done handshake. Optional macro SERIAL_SUB_OVF_EN
//            adds the signed overflow flag o_ovf.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_d_sh;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_bor;

  logic             w_a0;
  logic             w_b0;
  logic             w_hs1_d;
  logic             w_hs1_b;
  logic             w_d;
  logic             w_hs2_b;
  logic             w_bor_n;
  logic [WIDTH-1:0] w_d_next;

  // Full-subtractor cell: half-sub on (a0,b0), then half-sub on (d1,borrow-in)
  assign w_a0     = r_a_sh[0];
  assign w_b0     = r_b_sh[0];
  assign w_hs1_d  = w_a0 ^ w_b0;
  assign w_hs1_b  = ~w_a0 & w_b0;
  assign w_d      = w_hs1_d ^ r_bor;
  assign w_hs2_b  = ~w_hs1_d & r_bor;
  assign w_bor_n  = w_hs1_b | w_hs2_b;
  assign w_d_next = {w_d, r_d_sh[WIDTH-1:1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= c_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_d_sh   <= '0;
      r_cnt    <= '0;
      r_bor    <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_diff   <= '0;
      o_borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      o_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_a_sh  <= i_a;
            r_b_sh  <= i_b;
            r_bor   <= 1'b0;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
            r_state <= c_RUN;
          end else begin
            r_state <= c_IDLE;
          end
        end
        c_RUN: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_d_sh <= w_d_next;
          r_bor  <= w_bor_n;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            // Last bit: publish the completed word including this cycle's bit
            o_diff   <= w_d_next;
            o_borrow <= w_bor_n;
`ifdef SERIAL_SUB_OVF_EN
            o_ovf    <= r_bor ^ w_bor_n;
`endif
            o_done   <= 1'b1;
            o_busy   <= 1'b0;
            r_state  <= c_DONE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_sub_nbit.sv
// ============================================================================
// Module   : tb_serial_sub_nbit
// Purpose  : Self-checking bench for serial_sub_nbit (arithmetic model plus
//            directed vectors with literal expectations).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sub_nbit;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_diff;
  logic         o_borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         o_ovf;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  serial_sub_nbit #(.WIDTH(W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_diff   (o_diff),
    .o_borrow (o_borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .o_ovf    (o_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Model: an accepted request completes W edges later with plain arithmetic
  int           remain  = 0;
  logic         m_busy  = 1'b0;
  logic         m_done  = 1'b0;
  logic [W-1:0] m_diff  = '0;
  logic         m_bor   = 1'b0;
  logic         m_ovf   = 1'b0;
  logic [W-1:0] op_a    = '0;
  logic [W-1:0] op_b    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain = 0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_diff = '0;
      m_bor  = 1'b0;
      m_ovf  = 1'b0;
    end else if (remain > 0) begin
      remain = remain - 1;
      if (remain == 0) begin
        int sd;
        sd     = int'($signed(op_a)) - int'($signed(op_b));
        m_diff = op_a - op_b;
        m_bor  = (op_a < op_b);
        m_ovf  = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
        m_done = 1'b1;
        m_busy = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        op_a   = a;
        op_b   = b;
        remain = W;
        m_busy = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", 32'(o_busy), 32'(m_busy));
    chk("done", 32'(o_done), 32'(m_done));
    chk("diff", 32'(o_diff), 32'(m_diff));
    chk("borrow", 32'(o_borrow), 32'(m_bor));
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", 32'(o_ovf), 32'(m_ovf));
`endif
  end

  task automatic wait_done(input string name, input logic [W-1:0] ed,
                           input logic eb, input logic eo);
    bit found = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (o_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_diff"}, 32'(o_diff), 32'(ed));
      chk({name, "_borrow"}, 32'(o_borrow), 32'(eb));
      chk({name, "_model_diff"}, 32'(m_diff), 32'(ed));
      chk({name, "_model_borrow"}, 32'(m_bor), 32'(eb));
      chk({name, "_model_ovf"}, 32'(m_ovf), 32'(eo));
`ifdef SERIAL_SUB_OVF_EN
      chk({name, "_ovf"}, 32'(o_ovf), 32'(eo));
`endif
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    @(negedge clk);
    start = 1'b1;
    a     = va;
    b     = vb;
    @(negedge clk);
    start = 1'b0;
    wait_done(name, ed, eb, eo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_diff", 32'(o_diff), 32'd0);
    rst_n = 1'b1;

    run_op("a200_b55", 8'd200, 8'd55, 8'h91, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", 32'(o_done), 32'd0);
    run_op("a55_b200", 8'd55, 8'd200, 8'h6F, 1'b1, 1'b0);
    run_op("a0_b1", 8'd0, 8'd1, 8'hFF, 1'b1, 1'b0);
    run_op("equal", 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0);

    // Start during RUN must be ignored
    @(negedge clk);
    start = 1'b1; a = 8'd10; b = 8'd3;
    @(negedge clk);
    start = 1'b0; a = 8'd0; b = 8'd0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'd99; b = 8'd1;
    @(negedge clk);
    start = 1'b0; a = 8'd0; b = 8'd0;
    wait_done("ignore_start", 8'd7, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_diff", 32'(o_diff), 32'd7);
    chk("hold_idle_busy", 32'(o_busy), 32'd0);

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1; a = 8'd9; b = 8'd4;
    wait_done("b2b_first", 8'd5, 1'b0, 1'b0);
    t1 = cyc;
    a = 8'd4; b = 8'd9;
    @(negedge clk);
    start = 1'b0; a = 8'd0; b = 8'd0;
    wait_done("b2b_second", 8'hFB, 1'b1, 1'b0);
    chk("b2b_gap", 32'(cyc - t1), 32'(W + 1));

    run_op("ovf_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("ovf_10_20", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    start = 1'b1; a = 8'hC3; b = 8'h21;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(o_busy), 32'd0);
    chk("async_done", 32'(o_done), 32'd0);
    chk("async_diff", 32'(o_diff), 32'd0);
    chk("async_borrow", 32'(o_borrow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    chk("no_done_after_abort_diff", 32'(o_diff), 32'd0);
    run_op("after_reset", 8'h33, 8'h44, 8'hEF, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_sub_nbit.md
Name: serial_sub_nbit

Overview:
- Bit-serial N-bit subtractor: computes A - B, LSB first, one bit per clock.
- Uses a single full-subtractor cell built from two half-subtractors, plus a registered borrow flop.
- Counterpart to the combinational full-adder/half-adder cells. It serves area-constrained datapaths that trade latency for one 1-bit cell.
- Start/done handshake. The result is held in output registers until the next completion.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- i_clk  input  1  clock, rising-edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  request; sampled only when o_busy=0.
- i_a  input  WIDTH  minuend, captured on the accepted start edge.
- i_b  input  WIDTH  subtrahend, captured on the accepted start edge.
- o_busy  output  1  high while a subtraction is in progress.
- o_done  output  1  one-cycle pulse: result valid.
- o_diff  output  WIDTH  A - B modulo 2^WIDTH.
- o_borrow  output  1  final borrow-out; 1 means A < B unsigned.

Behaviour:
- Reset (async assert, sync release): state IDLE; o_busy=0, o_done=0, o_diff=0, o_borrow=0. Internal shift registers, counter and borrow flop are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: at edge E0 with i_start=1.
  - Load a_sh<=i_a, b_sh<=i_b, bor<=0, cnt<=0.
  - o_busy goes to 1 after E0.
- RUN, each edge with a0=a_sh[0], b0=b_sh[0]:
  - Cell: d = a0^b0^bor; bor_n = (~a0&b0) | (~(a0^b0)&bor).
  - Realised as half-sub 1 on (a0,b0) and half-sub 2 on (d1,bor); bor_n = OR of the two borrows.
  - a_sh and b_sh shift right; d shifts into d_sh from the MSB end.
  - bor<=bor_n; cnt<=cnt+1.
- RUN -> DONE: on the edge where cnt==WIDTH-1 (edge E_WIDTH). On that same edge:
  - o_diff<=final d_sh value (including this bit); o_borrow<=bor_n.
  - o_done<=1; o_busy<=0.
- DONE -> IDLE: on the next edge; o_done<=0.
  - If i_start=1 during DONE, it is accepted as in IDLE (back-to-back, goes straight to RUN).
- Latency: o_done is high in exactly the cycle after E_WIDTH, i.e. WIDTH edges after the start edge.
- Throughput: one result per WIDTH+1 cycles back-to-back.
- i_start while o_busy=1: ignored. No queuing and no effect on the running operation.
- i_a/i_b changes after acceptance: no effect.
- o_diff/o_borrow hold their last completed value through subsequent RUN phases. They update only at completion.
- Counter width: clog2(WIDTH) bits minimum. Wrap is never reached, because the RUN exit occurs at WIDTH-1.
- Reset mid-RUN: abort immediately, outputs cleared, no o_done pulse.
- Equal operands: o_diff=0, o_borrow=0.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined: adds port o_ovf (output, 1 bit), the signed two's-complement overflow flag.
  - o_ovf = borrow into MSB XOR borrow out of MSB, captured on the completion edge together with o_diff.
  - Same reset and hold rules as o_borrow.
- Undefined: port o_ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, A=200, B=55, start -> after 8 edges o_done=1 for one cycle, o_diff=145 (0x91), o_borrow=0.
- A=55, B=200 -> o_diff=111 (0x6F), o_borrow=1. Then A=0, B=1 -> o_diff=0xFF, o_borrow=1. A=0x5A, B=0x5A -> o_diff=0, o_borrow=0.
- Start A=10, B=3; pulse i_start with A=99, B=1 at cycle 3 of RUN -> single o_done, o_diff=7. o_diff stays 7 through the following idle cycles.
- Back-to-back: i_start held high continuously with A=9, B=4, then A=4, B=9 presented in the DONE cycle -> o_done pulses 9 cycles apart with 5/borrow 0, then 0xFB/borrow 1.
- Assert i_rst_n=0 at RUN cycle 4 -> o_busy, o_diff, o_borrow, o_done go 0 asynchronously. No o_done follows. A new start after release produces a correct result.
- With SERIAL_SUB_OVF_EN: A=0x80, B=0x01 -> o_diff=0x7F, o_ovf=1, o_borrow=0. A=0x10, B=0x20 -> o_diff=0xF0, o_ovf=0, o_borrow=1.
